// File: rtl/operand_entry.sv
// Front end of the 4-bit comparison unit: debounces the "next" button and steps
// through capturing X, capturing Y and showing the result.
module operand_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int COUNT_WIDTH     = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       keyNext_n,
  input  logic [3:0] switches,
  input  logic [1:0] opSel,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic [1:0] operation,
  output logic       valid,
  output logic [1:0] entryState
);

  typedef enum logic [1:0] {
    LOAD_X = 2'b00,
    LOAD_Y = 2'b01,
    SHOW   = 2'b10,
    BAD    = 2'b11
  } EntryState;

  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                   sync1;
  logic                   sync2;
  logic                   db;
  logic [COUNT_WIDTH-1:0] counter;
  logic                   pressPulse;
  EntryState              state;

  // Button is active-low, so the synchronizer inverts it; db=1 means pressed.
  // Only an accepted 0->1 transition of db generates a one-cycle press pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      db         <= 1'b0;
      counter    <= '0;
      pressPulse <= 1'b0;
    end else begin
      sync1      <= ~keyNext_n;
      sync2      <= sync1;
      pressPulse <= 1'b0;
      if (sync2 == db) begin
        counter <= '0;
      end else if (counter == LAST_COUNT) begin
        db         <= sync2;
        counter    <= '0;
        pressPulse <= sync2;
      end else begin
        counter <= counter + 1'b1;
      end
    end
  end

  // Operation tracks opSel on every SHOW edge, including the edge that enters SHOW.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD_X;
      x         <= 4'h0;
      y         <= 4'h0;
      operation <= 2'b00;
      valid     <= 1'b0;
    end else begin
      case (state)
        LOAD_X: begin
          if (pressPulse) begin
            x     <= switches;
            state <= LOAD_Y;
          end
        end
        LOAD_Y: begin
          if (pressPulse) begin
            y         <= switches;
            operation <= opSel;
            valid     <= 1'b1;
            state     <= SHOW;
          end
        end
        SHOW: begin
          operation <= opSel;
          if (pressPulse) begin
            valid <= 1'b0;
            state <= LOAD_X;
          end
        end
        default: begin
          valid <= 1'b0;
          state <= LOAD_X;
        end
      endcase
    end
  end

  assign entryState = state;

endmodule

// File: tb/tb_operand_entry.sv
// Directed-vector bench for operand_entry with a short debounce window.
module tb_operand_entry;

  localparam int DC = 4;
  localparam int CW = 3;

  logic       clk;
  logic       reset;
  logic       keyNext_n;
  logic [3:0] switches;
  logic [1:0] opSel;
  logic [3:0] x;
  logic [3:0] y;
  logic [1:0] operation;
  logic       valid;
  logic [1:0] entryState;

  int vectorsApplied = 0;
  int miscompares    = 0;
  int pulseCount     = 0;
  int pulseMark      = 0;

  operand_entry #(.DEBOUNCE_CYCLES(DC), .COUNT_WIDTH(CW)) dut (
    .clk(clk),
    .reset(reset),
    .keyNext_n(keyNext_n),
    .switches(switches),
    .opSel(opSel),
    .x(x),
    .y(y),
    .operation(operation),
    .valid(valid),
    .entryState(entryState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit later and pulses are tallied.
  task automatic tick();
    @(posedge clk);
    #1;
    if (dut.pressPulse === 1'b1) pulseCount++;
  endtask

  task automatic applyStimulus(input logic key, input logic [3:0] sw, input logic [1:0] op);
    keyNext_n = key;
    switches  = sw;
    opSel     = op;
  endtask

  function automatic logic [15:0] packOut();
    return {3'b000, x, y, operation, valid, entryState};
  endfunction

  function automatic logic [15:0] expOut(input logic [3:0] ex, input logic [3:0] ey,
                                         input logic [1:0] eop, input logic ev,
                                         input logic [1:0] es);
    return {3'b000, ex, ey, eop, ev, es};
  endfunction

  task automatic releaseButton();
    keyNext_n = 1'b1;
    repeat (8) tick();
  endtask

  task automatic pressButton();
    keyNext_n = 1'b0;
    repeat (7) tick();
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b1, 4'h0, 2'b00);
    tick();
    tick();
    checkOutput("reset_outputs", packOut(), expOut(4'h0, 4'h0, 2'b00, 1'b0, 2'b00));
    reset = 1'b0;

    // Idle with the button released.
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("idle_outputs", packOut(), expOut(4'h0, 4'h0, 2'b00, 1'b0, 2'b00));
    end

    // Clean press capturing X: pulse appears after edge k+5 only.
    applyStimulus(1'b0, 4'hA, 2'b00);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("press_no_pulse_yet", {15'b0, dut.pressPulse}, 16'h0000);
    end
    tick();
    checkOutput("press_pulse_k5", {15'b0, dut.pressPulse}, 16'h0001);
    checkOutput("state_before_capture", {14'b0, entryState}, 16'h0000);
    tick();
    checkOutput("press_pulse_gone", {15'b0, dut.pressPulse}, 16'h0000);
    checkOutput("capture_x", packOut(), expOut(4'hA, 4'h0, 2'b00, 1'b0, 2'b01));

    // Capture Y.
    switches  = 4'h3;
    pulseMark = pulseCount;
    releaseButton();
    checkOutput("release_no_pulse", 16'(pulseCount - pulseMark), 16'd0);
    checkOutput("x_ignores_switches", {12'b0, x}, 16'h000A);
    pressButton();
    checkOutput("capture_y", packOut(), expOut(4'hA, 4'h3, 2'b00, 1'b1, 2'b10));

    // Operation follows opSel with one edge of latency in SHOW.
    opSel = 2'b11;
    tick();
    checkOutput("op_11", {14'b0, operation}, 16'h0003);
    opSel = 2'b01;
    tick();
    checkOutput("op_01", {14'b0, operation}, 16'h0001);
    releaseButton();
    pressButton();
    checkOutput("show_to_load_x", packOut(), expOut(4'hA, 4'h3, 2'b01, 1'b0, 2'b00));
    releaseButton();

    // Bounce: low 3 / high 1 / low 2 / high, never long enough to accept.
    opSel     = 2'b10;
    switches  = 4'h7;
    pulseMark = pulseCount;
    keyNext_n = 1'b0; repeat (3) tick();
    keyNext_n = 1'b1; tick();
    keyNext_n = 1'b0; repeat (2) tick();
    keyNext_n = 1'b1; repeat (10) tick();
    checkOutput("bounce_no_pulse", 16'(pulseCount - pulseMark), 16'd0);
    checkOutput("bounce_no_change", packOut(), expOut(4'hA, 4'h3, 2'b01, 1'b0, 2'b00));

    // Long hold gives exactly one pulse and one advance.
    switches  = 4'h5;
    pulseMark = pulseCount;
    keyNext_n = 1'b0;
    repeat (50) tick();
    checkOutput("hold_one_pulse", 16'(pulseCount - pulseMark), 16'd1);
    checkOutput("hold_one_advance", packOut(), expOut(4'h5, 4'h3, 2'b01, 1'b0, 2'b01));
    releaseButton();

    // Reset in LOAD_Y with the debounce counter at 2.
    keyNext_n = 1'b0;
    repeat (4) tick();
    checkOutput("counter_at_2", {13'b0, dut.counter}, 16'd2);
    reset = 1'b1;
    tick();
    checkOutput("mid_reset_outputs", packOut(), expOut(4'h0, 4'h0, 2'b00, 1'b0, 2'b00));
    reset    = 1'b0;
    switches = 4'h9;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("post_reset_no_pulse", {15'b0, dut.pressPulse}, 16'h0000);
    end
    tick();
    checkOutput("post_reset_pulse", {15'b0, dut.pressPulse}, 16'h0001);
    tick();
    checkOutput("post_reset_capture", packOut(), expOut(4'h9, 4'h0, 2'b00, 1'b0, 2'b01));

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
